// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access stage: opcodes, FSM states,
// access sizes, error codes and lane helper functions.
package mem_pkg;

    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] LB  = 6'b100000;
    localparam logic [5:0] LBU = 6'b100100;
    localparam logic [5:0] LH  = 6'b100001;
    localparam logic [5:0] LHU = 6'b100101;
    localparam logic [5:0] SW  = 6'b101011;
    localparam logic [5:0] SB  = 6'b101000;
    localparam logic [5:0] SH  = 6'b101001;

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
    typedef enum logic [1:0] {BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2} size_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_RW       = 2'b11;

    // Unknown opcodes fall back to a word access.
    function automatic size_t op_size(input logic [5:0] op);
        case (op)
            LB, LBU, SB: return BYTE;
            LH, LHU, SH: return HALF;
            default:     return WORD;
        endcase
    endfunction

    function automatic logic op_signed(input logic [5:0] op);
        return (op == LB) || (op == LH);
    endfunction

    // Little-endian byte enables for the addressed lane(s).
    function automatic logic [3:0] lane_be(input size_t size, input logic [1:0] lo);
        case (size)
            BYTE:    return 4'b0001 << lo;
            HALF:    return lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Store data replicated so the selected lane carries it whatever the offset.
    function automatic logic [31:0] lane_wdata(input size_t size, input logic [31:0] data);
        case (size)
            BYTE:    return {4{data[7:0]}};
            HALF:    return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/halfword out of a 32-bit bus word and extends it.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  size_t       size,
    input  logic        is_signed,
    output logic [31:0] result
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    // Lane select followed by sign or zero extension.
    always_comb begin
        byte_val = rdata[7:0];
        case (addr_lo)
            2'd1:    byte_val = rdata[15:8];
            2'd2:    byte_val = rdata[23:16];
            2'd3:    byte_val = rdata[31:24];
            default: byte_val = rdata[7:0];
        endcase
        half_val = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            BYTE:    result = {{24{is_signed & byte_val[7]}}, byte_val};
            HALF:    result = {{16{is_signed & half_val[15]}}, half_val};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access32.sv
// Data-memory access stage: runs one bus transaction per load/store, stalls
// the core while it is outstanding, and flags misalignment and bus timeout.
module mem_access32
    import mem_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] IO_BASE        = 32'hFFFFFC00
)
(
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [5:0]  opcode,
    input  logic [31:0] alu_result,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        stall,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        io_sel,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ready
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    size_t            size_reg;
    logic             signed_reg;
    logic [1:0]       lo_reg;

    size_t       req_size;
    logic        req_any, req_both, misaligned, req_ok, req_err, timed_out;
    logic [31:0] load_value;

    // Request decode: a request is either launched on the bus or rejected with an error.
    always_comb begin
        req_size   = op_size(opcode);
        req_any    = mem_read | mem_write;
        req_both   = mem_read & mem_write;
        misaligned = ((req_size == WORD) && (alu_result[1:0] != 2'b00)) ||
                     ((req_size == HALF) && alu_result[0]);
        req_ok     = req_any & ~req_both & ~misaligned;
        req_err    = req_any & (req_both | misaligned);
        // True on the last BUSY cycle allowed before abort.
        timed_out  = (cnt_reg == CNT_LAST);
    end

    load_align u_load_align (
        .rdata     (bus_rdata),
        .addr_lo   (lo_reg),
        .size      (size_reg),
        .is_signed (signed_reg),
        .result    (load_value)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and stall; stall rises in the same cycle a valid request arrives.
    always_comb begin
        state_next = state_reg;
        stall      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_ok) begin
                    stall      = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (bus_ready || timed_out) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus launch, response capture, timeout counting and error pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            read_data  <= '0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            bus_be     <= '0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            io_sel     <= 1'b0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
            cnt_reg    <= '0;
            size_reg   <= WORD;
            signed_reg <= 1'b0;
            lo_reg     <= 2'b00;
        end else begin
            err      <= 1'b0;
            err_code <= ERR_NONE;
            case (state_reg)
                IDLE: begin
                    if (req_ok) begin
                        bus_addr   <= {alu_result[31:2], 2'b00};
                        bus_be     <= lane_be(req_size, alu_result[1:0]);
                        bus_wdata  <= lane_wdata(req_size, write_data);
                        bus_we     <= mem_write;
                        io_sel     <= (alu_result >= IO_BASE);
                        size_reg   <= req_size;
                        signed_reg <= op_signed(opcode);
                        lo_reg     <= alu_result[1:0];
                        bus_req    <= 1'b1;
                        cnt_reg    <= '0;
                    end else if (req_err) begin
                        err      <= 1'b1;
                        err_code <= req_both ? ERR_RW : ERR_MISALIGN;
                    end
                end
                BUSY: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (bus_ready) begin
                        bus_req <= 1'b0;
                        if (!bus_we) begin
                            read_data <= load_value;
                        end
                    end else if (timed_out) begin
                        bus_req   <= 1'b0;
                        read_data <= '0;
                        err       <= 1'b1;
                        err_code  <= ERR_TIMEOUT;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mem_access32.md
Name: mem_access32

Overview:
- Data-memory access stage directly downstream of the execute stage.
- Consumes the ALU result as the effective address and the rt register value as store data.
- Runs a request/ready transaction on the data bus and stalls the core while the access is outstanding.
- Handles byte, halfword and word lanes, load sign/zero extension, misalignment and bus timeout.

Parameters:
- TIMEOUT_CYCLES, 255: BUSY cycles without bus_ready before the access is aborted.
- IO_BASE, 32'hFFFFFC00: addresses greater than or equal to this assert io_sel for the memory-mapped I/O decoder.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- mem_read  in  1  load request from the controller.
- mem_write  in  1  store request from the controller.
- opcode  in  6  instruction opcode: lw 100011, lb 100000, lbu 100100, lh 100001, lhu 100101, sw 101011, sb 101000, sh 101001.
- alu_result  in  32  effective address.
- write_data  in  32  rt value to store.
- read_data  out  32  extended load result, registered.
- stall  out  1  freeze PC and pipeline.
- err  out  1  one-cycle error pulse.
- err_code  out  2  00 none, 01 misaligned, 10 timeout, 11 read and write both asserted.
- io_sel  out  1  registered: current access targets I/O space.
- bus_req  out  1  bus request.
- bus_we  out  1  write strobe.
- bus_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_rdata  in  32  read data, valid when bus_ready is high.
- bus_ready  in  1  transaction complete.

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset (asynchronous): state=IDLE; read_data, bus_addr, bus_wdata = 0; bus_be=0; bus_req, bus_we, err, io_sel = 0; err_code=0; timeout counter=0. Reset mid-BUSY abandons the transaction immediately; bus_req drops asynchronously.
- IDLE, no request: stall=0.
- IDLE, valid request (exactly one of mem_read/mem_write, address aligned):
  - stall=1 combinationally in the same cycle.
  - At the clock edge, latch bus_addr, bus_be, bus_wdata, bus_we, io_sel and the load type; set bus_req=1; go to BUSY.
- IDLE, misaligned request (word with addr[1:0]!=0; half with addr[0]!=0):
  - No bus transaction; stall=0.
  - err=1 with err_code=01 on the following cycle (registered pulse); stay in IDLE.
- IDLE, mem_read and mem_write both high: same handling, err_code=11.
- BUSY:
  - stall=1; bus_req and all latched bus outputs are held stable.
  - Counter increments each cycle.
  - bus_ready=1: capture the extended bus_rdata into read_data (loads only), drop bus_req, go to DONE. Total latency = bus wait states + 2 cycles.
  - Counter reaches TIMEOUT_CYCLES without ready: drop bus_req, read_data=0, err=1 with err_code=10 for one cycle, go to DONE.
  - bus_ready on the same cycle the timeout is reached: ready wins, no error.
- DONE:
  - stall=0 for exactly one cycle; read_data valid; go to IDLE.
  - Request inputs are ignored in DONE, so the held instruction does not reissue.
- Lanes are little-endian: byte k = bits 8k+7:8k, k=addr[1:0].
  - sb: bus_be=1<<k, byte replicated on all four lanes.
  - sh: bus_be=0011 or 1100 per addr[1], halfword replicated on both halves.
  - sw: bus_be=1111.
  - Loads drive the same bus_be pattern with bus_we=0.
- Load extension: lb/lh sign-extend; lbu/lhu zero-extend; lw passes through.
- An unknown opcode with mem_read or mem_write set is treated as a word access.
- bus_ready while not in BUSY is ignored.

Decomposition:
- Package mem_pkg holds:
  - opcode constants LW, LB, LBU, LH, LHU, SW, SB, SH;
  - state enum IDLE/BUSY/DONE;
  - err_code constants;
  - size encoding (BYTE, HALF, WORD).
- One combinational sub-module, load_align: takes bus_rdata, addr[1:0], size and is_signed; returns the extended 32-bit value. It is reused by the I/O read path.

Test Plan:
- lw: alu_result=0x00000010, bus_ready after 2 wait cycles, bus_rdata=0x12345678 -> bus_be=1111, stall high for 4 cycles, read_data=0x12345678 in DONE, err=0.
- lb/lbu: addr=0x00000013, bus_rdata=0x80FFFFFF -> bus_be=1000; read_data=0xFFFFFF80 for lb, 0x00000080 for lbu.
- sh: addr=0x00000022, write_data=0x0000ABCD -> bus_we=1, bus_be=1100, bus_wdata=0xABCDABCD; read_data unchanged.
- Misaligned lw: addr=0x00000006 -> bus_req never asserted, stall=0, one-cycle err with err_code=01.
- Timeout: TIMEOUT_CYCLES=4, bus_ready held low -> bus_req drops after 4 BUSY cycles, err_code=10 pulse, DONE then IDLE.
- Reset mid-BUSY, then sw to IO_BASE+4 -> bus_req=0 and state=IDLE immediately on reset; the following store shows io_sel=1 and bus_addr=0xFFFFFC04.
